zycap_xfer_ctrl: RTL and testbench
==================================

Name: zycap_xfer_ctrl

Overview:
Upstream feeder for the ICAP stream stage. Sits between the partial-bitstream DMA (AXI4-Stream master) and the ICAP sink. Accepts a software-programmed word count, buffers the stream in a small FIFO and enforces length/TLAST consistency. Adds a stall timeout, reports sync-word detection and returns a done/error status to the control register block.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2
LEN_WIDTH, 24, width of the transfer length and word counter, in 32-bit words
SYNC_WORD, 32'hAA995566, sync pattern compared against S_AXIS_TDATA as received (no byte/bit reordering)
TIMEOUT_CYCLES, 65535, idle-cycle limit before a timeout abort

Ports:
ACLK  in  1  clock for all logic
ARESETN  in  1  synchronous active-low reset, sampled on the ACLK rising edge
START  in  1  one-cycle pulse that launches a transfer; honoured only in IDLE
LENGTH  in  LEN_WIDTH  expected word count, sampled with START
BUSY  out  1  high in RUN and DRAIN
DONE  out  1  one-cycle completion pulse; also fires on any error
ERR  out  3  0 none, 1 zero length, 2 early TLAST, 3 missing TLAST, 4 timeout
SYNC_SEEN  out  1  SYNC_WORD accepted during the current transfer
WORD_COUNT  out  LEN_WIDTH  words accepted in the current transfer
S_AXIS_TDATA  in  32  DMA data
S_AXIS_TVALID  in  1  DMA valid
S_AXIS_TLAST  in  1  DMA last
S_AXIS_TREADY  out  1  ready to DMA
M_AXIS_TDATA  out  32  data to ICAP stage
M_AXIS_TVALID  out  1  valid to ICAP stage
M_AXIS_TLAST  out  1  last to ICAP stage
M_AXIS_TREADY  in  1  ready from ICAP stage (may be tied high)

Behaviour:
- Reset (ARESETN=0 at an edge): state IDLE, FIFO emptied, every output 0 from the following cycle. Reset mid-transfer discards buffered words and sends no TLAST.
- States: IDLE, RUN, DRAIN.
- IDLE: S_AXIS_TREADY=0.
  - START with LENGTH!=0: latch LENGTH, clear WORD_COUNT, ERR and SYNC_SEEN, go to RUN.
  - START with LENGTH=0: ERR=1, DONE pulses the next cycle, stay in IDLE.
- START outside IDLE is ignored.
- RUN: S_AXIS_TREADY = FIFO not full. It is registered and does not depend on a same-cycle pop.
- Accept = S_AXIS_TVALID & S_AXIS_TREADY.
  - Each accept pushes {TDATA, last_flag} into the FIFO and increments WORD_COUNT.
  - An accept with TDATA==SYNC_WORD sets SYNC_SEEN.
- Termination conditions; each moves to DRAIN on the next edge:
  - Accept with WORD_COUNT==latched LENGTH-1 and TLAST=1: normal end, ERR=0, last_flag=1.
  - Accept with WORD_COUNT==LENGTH-1 and TLAST=0: ERR=3, last_flag=1.
  - Accept with TLAST=1 before the final word: ERR=2, last_flag=1.
  - Timeout: a counter increments on every RUN cycle with no accept and resets on any accept. Reaching TIMEOUT_CYCLES sets ERR=4; no word is marked last.
- DRAIN: S_AXIS_TREADY=0. When the FIFO becomes empty (last pop accepted), DONE pulses one cycle and the state returns to IDLE. BUSY falls in the same cycle DONE rises.
- Words offered after termination are not accepted; they stay pending on the DMA side.
- FIFO / M side:
  - M_AXIS_TVALID = FIFO not empty.
  - M_AXIS_TDATA and M_AXIS_TLAST come from the head entry; TLAST = last_flag.
  - Pop on M_AXIS_TVALID & M_AXIS_TREADY.
  - Simultaneous push and pop are allowed when the FIFO is neither empty-and-popping nor full.
  - Pointers are LOG2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- Latency: a word accepted at edge N is visible on M_AXIS_TVALID/TDATA after edge N, i.e. one cycle, first-word fall-through. With M_AXIS_TREADY=1 throughput is one word per cycle.
- ERR, SYNC_SEEN and WORD_COUNT hold their values after DONE until the next honoured START.
- WORD_COUNT saturates at LENGTH; no wrap.

Test Plan:
- LENGTH=4, four words 0xFFFFFFFF, 0xAA995566, 1, 2 with TLAST on the 4th, M_TREADY=1 -> identical M stream one cycle later, TLAST on 0x2, SYNC_SEEN=1, DONE one cycle after the last pop, ERR=0, WORD_COUNT=4.
- LENGTH=3, TLAST on word 2 -> 2 words forwarded, 2nd with TLAST, ERR=2, 3rd word not accepted (S_TREADY=0).
- LENGTH=2, no TLAST -> ERR=3, M_TLAST on word 2, DONE pulse.
- FIFO_DEPTH=16, M_TREADY=0, 20 words offered -> exactly 16 accepted, S_TREADY low; after M_TREADY=1 all words exit in order with no loss or duplication.
- TIMEOUT_CYCLES=8, LENGTH=5, only 1 word sent -> ERR=4 after 8 idle cycles, DONE once the FIFO drains, WORD_COUNT=1.
- START with LENGTH=0 -> ERR=1, DONE on the next cycle, BUSY stays 0. ARESETN low mid-RUN -> all outputs 0, FIFO empty, state IDLE.

Source files
------------

// File: rtl/zycap_xfer_ctrl.sv
// DMA-to-ICAP word feeder: buffers the stream in a FWFT FIFO and polices LENGTH against TLAST and stalls.
// One cycle S->M latency; S_AXIS_TREADY is low outside RUN or when the FIFO is full, and the M side stalls on M_AXIS_TREADY.

module zycap_xfer_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     full,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

module zycap_xfer_ctrl #(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          LEN_WIDTH      = 24,
    parameter logic [31:0] SYNC_WORD      = 32'hAA995566,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] LENGTH,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2:0]           ERR,
    output logic                 SYNC_SEEN,
    output logic [LEN_WIDTH-1:0] WORD_COUNT,
    input  logic [31:0]          S_AXIS_TDATA,
    input  logic                 S_AXIS_TVALID,
    input  logic                 S_AXIS_TLAST,
    output logic                 S_AXIS_TREADY,
    output logic [31:0]          M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    output logic                 M_AXIS_TLAST,
    input  logic                 M_AXIS_TREADY
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ZERO_LEN   = 3'd1;
    localparam logic [2:0] ERR_EARLY_LAST = 3'd2;
    localparam logic [2:0] ERR_NO_LAST    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, word_count_q, word_count_d;
    logic [2:0]           err_q, err_d;
    logic                 sync_seen_q, sync_seen_d;
    logic                 done_q, done_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic          fifo_full, fifo_empty, accept, pop, final_word, push_last, drained;
    logic [LW-1:0] fifo_level;
    logic [32:0]   head_dat;

    assign S_AXIS_TREADY = (state_q == RUN) & ~fifo_full;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign final_word    = (word_count_q == len_q - LEN_WIDTH'(1));
    assign push_last     = final_word | S_AXIS_TLAST;
    assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
    assign drained       = fifo_empty | (pop & (fifo_level == LW'(1)));

    zycap_xfer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .push_vld (accept),
        .push_dat ({S_AXIS_TDATA, push_last}),
        .full     (fifo_full),
        .pop_rdy  (M_AXIS_TREADY),
        .pop_dat  (head_dat),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Head data is masked while empty so the port never shows stale memory.
    assign M_AXIS_TVALID = ~fifo_empty;
    assign M_AXIS_TDATA  = fifo_empty ? 32'd0 : head_dat[32:1];
    assign M_AXIS_TLAST  = ~fifo_empty & head_dat[0];

    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign SYNC_SEEN  = sync_seen_q;
    assign WORD_COUNT = word_count_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        sync_seen_d  = sync_seen_q;
        done_d       = 1'b0;
        tmo_d        = tmo_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    word_count_d = '0;
                    sync_seen_d  = 1'b0;
                    tmo_d        = '0;
                    if (LENGTH == '0) begin
                        err_d  = ERR_ZERO_LEN;
                        done_d = 1'b1;
                    end else begin
                        len_d   = LENGTH;
                        err_d   = ERR_NONE;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    tmo_d = '0;
                    if (word_count_q != len_q) word_count_d = word_count_q + LEN_WIDTH'(1);
                    if (S_AXIS_TDATA == SYNC_WORD) sync_seen_d = 1'b1;
                    if (final_word) begin
                        err_d   = S_AXIS_TLAST ? ERR_NONE : ERR_NO_LAST;
                        state_d = DRAIN;
                    end else if (S_AXIS_TLAST) begin
                        err_d   = ERR_EARLY_LAST;
                        state_d = DRAIN;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            err_q        <= ERR_NONE;
            sync_seen_q  <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            sync_seen_q  <= sync_seen_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
        end
    end
endmodule

// File: tb/tb_zycap_xfer_ctrl.sv
// Scoreboard bench for zycap_xfer_ctrl: expected M-side words are queued as the DMA side is accepted.
module tb_zycap_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] length = '0;
    logic        busy, done, sync_seen, s_tready, m_tvalid, m_tlast;
    logic [2:0]  err;
    logic [23:0] word_count;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tready = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_w;

    always #5 clk = ~clk;

    zycap_xfer_ctrl #(
        .FIFO_DEPTH     (16),
        .LEN_WIDTH      (24),
        .SYNC_WORD      (32'hAA995566),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .START         (start),
        .LENGTH        (length),
        .BUSY          (busy),
        .DONE          (done),
        .ERR           (err),
        .SYNC_SEEN     (sync_seen),
        .WORD_COUNT    (word_count),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready)
    );

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL m_stream_extra: got data=%h last=%b, required no word", m_tdata, m_tlast);
            end else begin
                exp_w = exp_q.pop_front();
                if ({m_tdata, m_tlast} !== exp_w) begin
                    bad++;
                    $display("FAIL m_stream: got data=%h last=%b, required data=%h last=%b",
                             m_tdata, m_tlast, exp_w[32:1], exp_w[0]);
                end
            end
        end
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [23:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic flag,
                        input int max_wait, output bit acc);
        acc      = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            if (s_tready) begin
                exp_q.push_back({d, flag});
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, err, sync_seen, word_count, s_tready, m_tdata, m_tvalid, m_tlast} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%0d sync=%b wc=%0d s_rdy=%b m_vld=%b, required all 0",
                     busy, done, err, sync_seen, word_count, s_tready, m_tvalid);
        end
    endtask

    task automatic test_basic();
        bit acc;
        int n_acc;
        n_acc = 0;
        m_tready = 1'b1;
        pulse_start(24'd4);
        total++;
        if (busy !== 1'b1 || s_tready !== 1'b1) begin
            bad++;
            $display("FAIL start_run: busy=%b s_tready=%b, required 1 1", busy, s_tready);
        end
        send(32'hFFFFFFFF, 1'b0, 1'b0, 4, acc);
        n_acc += int'(acc);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL fwft_latency: m_tvalid=%b m_tdata=%h, required 1 ffffffff", m_tvalid, m_tdata);
        end
        send(32'hAA995566, 1'b0, 1'b0, 4, acc);
        n_acc += int'(acc);
        pulse_start(24'd7);
        send(32'h1, 1'b0, 1'b0, 4, acc);
        n_acc += int'(acc);
        send(32'h2, 1'b1, 1'b1, 4, acc);
        n_acc += int'(acc);
        total++;
        if (n_acc != 4 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL basic_accept: accepted=%0d s_tready=%b, required 4 0", n_acc, s_tready);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || m_tlast !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_last: done=%b m_tlast=%b busy=%b, required 0 1 1", done, m_tlast, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_timing: done=%b busy=%b, required 1 0", done, busy);
        end
        total++;
        if (err !== 3'd0 || word_count !== 24'd4 || sync_seen !== 1'b1) begin
            bad++;
            $display("FAIL basic_status: err=%0d wc=%0d sync=%b, required 0 4 1", err, word_count, sync_seen);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || err !== 3'd0 || word_count !== 24'd4) begin
            bad++;
            $display("FAIL done_pulse_hold: done=%b err=%0d wc=%0d, required 0 0 4", done, err, word_count);
        end
    endtask

    task automatic test_early_last();
        bit a0, a1, a2;
        int d0;
        d0 = done_cnt;
        m_tready = 1'b1;
        pulse_start(24'd3);
        send(32'h11, 1'b0, 1'b0, 4, a0);
        send(32'h22, 1'b1, 1'b1, 4, a1);
        send(32'h33, 1'b0, 1'b0, 6, a2);
        total++;
        if (!a0 || !a1 || a2) begin
            bad++;
            $display("FAIL early_accept: accepted=%b%b%b, required 110", a0, a1, a2);
        end
        total++;
        if (err !== 3'd2 || word_count !== 24'd2 || sync_seen !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL early_status: err=%0d wc=%0d sync=%b busy=%b, required 2 2 0 0",
                     err, word_count, sync_seen, busy);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL early_done: pulses=%0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_no_last();
        bit acc, ok;
        int d0;
        d0 = done_cnt;
        pulse_start(24'd2);
        send(32'h5A, 1'b0, 1'b0, 4, acc);
        send(32'h5B, 1'b0, 1'b1, 4, acc);
        wait_done(d0 + 1, 10, ok);
        total++;
        if (!ok || err !== 3'd3 || word_count !== 24'd2) begin
            bad++;
            $display("FAIL no_last: done_seen=%b err=%0d wc=%0d, required 1 3 2", ok, err, word_count);
        end
    endtask

    task automatic test_full();
        bit acc, ok;
        int n_acc, d0;
        n_acc = 0;
        d0 = done_cnt;
        m_tready = 1'b0;
        pulse_start(24'd20);
        for (int i = 0; i < 16; i++) begin
            send(32'h1000 + i, 1'b0, 1'b0, 3, acc);
            n_acc += int'(acc);
        end
        send(32'h1010, 1'b0, 1'b0, 4, acc);
        total++;
        if (n_acc != 16 || acc !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL full_stop: accepted=%0d extra=%b s_tready=%b, required 16 0 0", n_acc, acc, s_tready);
        end
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h1000) begin
            bad++;
            $display("FAIL full_head: m_tvalid=%b m_tdata=%h, required 1 00001000", m_tvalid, m_tdata);
        end
        m_tready = 1'b1;
        for (int i = 16; i < 20; i++) begin
            send(32'h1000 + i, i == 19, i == 19, 20, acc);
            n_acc += int'(acc);
        end
        wait_done(d0 + 1, 40, ok);
        total++;
        if (!ok || n_acc != 20 || err !== 3'd0 || word_count !== 24'd20 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_drain: done_seen=%b accepted=%0d err=%0d wc=%0d pending=%0d, required 1 20 0 20 0",
                     ok, n_acc, err, word_count, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit acc;
        m_tready = 1'b1;
        pulse_start(24'd5);
        send(32'h77, 1'b0, 1'b0, 4, acc);
        repeat (8) @(negedge clk);
        total++;
        if (busy !== 1'b1 || err !== 3'd0) begin
            bad++;
            $display("FAIL timeout_early: busy=%b err=%0d, required 1 0", busy, err);
        end
        @(negedge clk);
        total++;
        if (err !== 3'd4 || busy !== 1'b1 || done !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: err=%0d busy=%b done=%b s_tready=%b, required 4 1 0 0",
                     err, busy, done, s_tready);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 24'd1) begin
            bad++;
            $display("FAIL timeout_done: done=%b busy=%b wc=%0d, required 1 0 1", done, busy, word_count);
        end
    endtask

    task automatic test_zero_len();
        pulse_start(24'd0);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || err !== 3'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: done=%b err=%0d busy=%b, required 1 1 0", done, err, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 3'd1) begin
            bad++;
            $display("FAIL zero_len_after: done=%b busy=%b err=%0d, required 0 0 1", done, busy, err);
        end
    endtask

    task automatic test_reset_mid_run();
        bit acc, ok;
        int d0;
        m_tready = 1'b0;
        pulse_start(24'd10);
        send(32'hAA995566, 1'b0, 1'b0, 4, acc);
        send(32'hC1, 1'b0, 1'b0, 4, acc);
        send(32'hC2, 1'b0, 1'b0, 4, acc);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total++;
        if ({busy, done, err, sync_seen, word_count, s_tready, m_tdata, m_tvalid, m_tlast} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b err=%0d sync=%b wc=%0d s_rdy=%b m_vld=%b, required all 0",
                     busy, done, err, sync_seen, word_count, s_tready, m_tvalid);
        end
        m_tready = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flush: m_tvalid=%b busy=%b, required 0 0", m_tvalid, busy);
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        pulse_start(24'd1);
        send(32'h99, 1'b1, 1'b1, 4, acc);
        wait_done(d0 + 1, 10, ok);
        total++;
        if (!ok || err !== 3'd0 || word_count !== 24'd1) begin
            bad++;
            $display("FAIL reset_recover: done_seen=%b err=%0d wc=%0d, required 1 0 1", ok, err, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_last();
        test_no_last();
        test_full();
        test_timeout();
        test_zero_len();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: pending=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
